item_memory_loader: RTL and testbench
=====================================

# item_memory_loader

Writer side of the per-core item-memory load port (`matw` / `mat_a` / `rand_num`). On a `start` command it fills the item memory of every core with pseudo-random 32-bit hypervectors, one write per clock. Each core receives its own address-ascending block of `num_items` words, generated by a xorshift32 sequence from a software seed. It sits between the host control registers and the core array, and runs while cores are held out of `run`; `busy` gates `run` upstream.

## Interface

Parameters:

- `NCORE`, 8, number of cores; width of the one-hot `matw` bus.
- `DEPTH`, 1024, item-memory entries per core; upper clamp for `num_items`.

Ports:

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  load request; sampled only in IDLE.
- `abort`  in  1  cancels a load in progress.
- `seed`  in  32  xorshift seed, captured on accepted `start`.
- `num_items`  in  16  words per core, captured on accepted `start`.
- `matw`  out  NCORE  one-hot write strobe, bit c addresses core c.
- `mat_a`  out  16  item-memory address.
- `rand_num`  out  32  write data.
- `busy`  out  1  high from start acceptance until completion or abort.
- `done`  out  1  one-cycle pulse after the final write.

## Operation

- States: IDLE, WRITE, FIN.
- **IDLE**
  - `start`=1 and `abort`=0: capture `seed` → `x` and `n` = min(`num_items`, `DEPTH`); set core=0, addr=0; go to WRITE.
  - `start` with `abort`: ignored.
- **Seed and count handling**
  - `seed`=0 is replaced by 32'h1, because 0 is the xorshift fixed point.
  - `n`=0: go directly to FIN with no writes.
- **WRITE**, each cycle:
  - `x` ← xs(`x`), where xs(v) applies, in order: v^=v<<13; v^=v>>17; v^=v<<5. All operations are 32-bit and the shifted-out bits are discarded.
  - Registered outputs: `matw` = 1<<core, `mat_a` = addr, `rand_num` = the new `x`.
  - addr increments. When addr = `n`-1, addr wraps to 0 and core increments.
  - After the write with core = `NCORE`-1 and addr = `n`-1: go to FIN.
- **Write sequence**
  - Total writes W = `NCORE`·`n`, issued with no gaps.
  - Write k (k = 0..W-1) carries xs applied k+1 times to the seed.
  - The sequence continues across core boundaries; it is not re-seeded per core.
- **FIN**: `matw`=0, `done`=1 for one cycle, `busy`=0, then go to IDLE.
- **abort** in WRITE: the next cycle has `matw`=0 and `busy`=0 and the state is IDLE. `done` is not pulsed, and writes already issued are not undone.
- **start while busy**: ignored; the captured `seed` and `n` are unaffected by input changes.
- **rst** asserted at any time: immediately `matw`=0, `mat_a`=0, `rand_num`=0, `busy`=0, `done`=0, `x`=1, state IDLE. A load in flight is dropped.

## Timing

- All outputs are registered. Reset value of every output is 0.
- `start` accepted at edge E0:
  - `busy`=1 after E0.
  - First write is presented after E1 and consumed by the core at E2.
- Write k is presented after edge E(k+1).
- The last write is presented after E(W).
- After E(W+1): `matw`=0, `done`=1, `busy`=0.
- After E(W+2): `done`=0. A new `start` is accepted from E(W+2) onward.
- Latency from start to done = W+1 cycles.
- `n`=0: `done` after E1, with no `matw` activity.
- At most one bit of `matw` is high in any cycle. `mat_a` < `n` whenever `matw` ≠ 0.
- `abort` sampled at edge Ea: a write presented after Ea-1 is still consumed; no write is presented after Ea.

## Test plan

- Reset mid-load:
  - Stimulus: assert `rst` between clock edges at write 5.
  - Response: outputs are 0 asynchronously.
  - A following `start` with `seed`=1 must restart from write 0 = 32'h00042021.
- Basic load:
  - Stimulus: `NCORE`=8, `seed`=1, `num_items`=4.
  - Response: 32 consecutive writes.
  - Write 0: `matw`=8'h01, `mat_a`=0, `rand_num`=32'h00042021.
  - Write 4: `matw`=8'h02, `mat_a`=0.
  - `done` pulses 33 cycles after acceptance, and each `rand_num` matches the xorshift32 reference model.
- Zero seed and clamp:
  - `seed`=0: first word is 32'h00042021.
  - `num_items`=2000: each core receives exactly 1024 writes, `mat_a` from 0 to 1023.
- Zero count:
  - Stimulus: `num_items`=0.
  - Response: no `matw` activity; `done` after E1; `busy` high for 1 cycle.
- Abort:
  - Stimulus: assert `abort` during write 10 of 32.
  - Response: writes 0..10 are issued; `matw`=0 and `busy`=0 on the next cycle; no `done`.
  - A subsequent `start` runs a full load.
- Start while busy:
  - Stimulus: pulse `start` with a new `seed`/`num_items` mid-load.
  - Response: the sequence and length are unchanged; exactly one `done`.

Source files
------------

// File: rtl/item_memory_loader_if.sv
// item_memory_loader_if: host command and item-memory write bus.
// master = loader (takes start/abort/seed/num_items, drives matw/mat_a/rand_num/busy/done).
`timescale 1ns/1ps
interface item_memory_loader_if #(
  parameter int NCORE = 8
);
  logic             start;
  logic             abort;
  logic [31:0]      seed;
  logic [15:0]      num_items;
  logic [NCORE-1:0] matw;
  logic [15:0]      mat_a;
  logic [31:0]      rand_num;
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, seed, num_items,
    output matw, mat_a, rand_num, busy, done
  );

  modport slave (
    output start, abort, seed, num_items,
    input  matw, mat_a, rand_num, busy, done
  );
endinterface

// File: rtl/item_memory_loader.sv
// item_memory_loader: fills every core's item memory with xorshift32 words.
// Ports: clk, rst (async high), bus (master: start/abort/seed/num_items in; matw/mat_a/rand_num/busy/done out).
`timescale 1ns/1ps
module item_memory_loader #(
  parameter int NCORE = 8,
  parameter int DEPTH = 1024
) (
  input logic                 clk,
  input logic                 rst,
  item_memory_loader_if.master bus
);

  localparam int CW = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam logic [CW-1:0]    LAST_CORE = CW'(NCORE - 1);
  localparam logic [15:0]      DEPTH16   = 16'(DEPTH);
  localparam logic [NCORE-1:0] ONE       = NCORE'(1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FIN
  } state_t;

  state_t        state;
  logic [31:0]   x;
  logic [15:0]   n;
  logic [15:0]   addr;
  logic [CW-1:0] core;

  function automatic logic [31:0] xs(
    input logic [31:0] v
  );
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  logic [31:0] x_nxt;
  logic [15:0] n_clamp;
  logic [31:0] seed_fix;
  logic        last_addr;
  logic        last_core;

  assign x_nxt     = xs(x);
  assign n_clamp   = (bus.num_items > DEPTH16)
                   ? DEPTH16 : bus.num_items;
  // zero is the xorshift fixed point
  assign seed_fix  = (bus.seed == 32'd0)
                   ? 32'd1 : bus.seed;
  assign last_addr = (addr == n - 16'd1);
  assign last_core = (core == LAST_CORE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      x            <= 32'd1;
      n            <= '0;
      addr         <= '0;
      core         <= '0;
      bus.matw     <= '0;
      bus.mat_a    <= '0;
      bus.rand_num <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.matw <= '0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            x        <= seed_fix;
            n        <= n_clamp;
            addr     <= '0;
            core     <= '0;
            bus.busy <= 1'b1;
            state    <= (n_clamp == 16'd0)
                      ? FIN : WRITE;
          end
        end
        WRITE: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            x            <= x_nxt;
            bus.matw     <= ONE << core;
            bus.mat_a    <= addr;
            bus.rand_num <= x_nxt;
            if (last_addr) begin
              addr <= '0;
              core <= core + CW'(1);
              if (last_core) begin
                state <= FIN;
              end
            end else begin
              addr <= addr + 16'd1;
            end
          end
        end
        FIN: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_item_memory_loader.sv
// tb_item_memory_loader: scoreboard bench with a behavioural xorshift model.
// Stimulus pushes expected writes; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_item_memory_loader;

  localparam int NCORE = 8;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  item_memory_loader_if #(.NCORE(NCORE)) bus();

  item_memory_loader #(
    .NCORE(NCORE),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          k;
    int          core;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          nwrites = 0;
  int          ndone = 0;
  int          max_addr = 0;
  logic [31:0] first_data = '0;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // monitor: every presented write must match the head of the queue
  always @(negedge clk) begin : mon
    wr_t e;
    logic [NCORE-1:0] m;
    if (rst === 1'b0) begin
      if (bus.matw !== '0) begin
        nwrites++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected write: matw %0h mat_a %0d",
                   bus.matw, bus.mat_a);
        end else begin
          e = exp_q.pop_front();
          m = '0;
          m[e.core] = 1'b1;
          chk("write matw", 32'(bus.matw), 32'(m));
          chk("write mat_a", 32'(bus.mat_a), 32'(e.addr));
          chk("write rand_num", bus.rand_num, e.data);
          if (e.k == 0) first_data = bus.rand_num;
          if (int'(bus.mat_a) > max_addr) max_addr = int'(bus.mat_a);
        end
      end
      if (bus.done === 1'b1) ndone++;
    end
  end

  // reference: W = NCORE*n words, write k = xs^(k+1)(seed)
  task automatic push_model(input logic [31:0] s,
                            input int num,
                            output int w);
    int n;
    logic [31:0] v;
    n = (num > DEPTH) ? DEPTH : num;
    v = (s == 32'd0) ? 32'd1 : s;
    w = NCORE * n;
    for (int k = 0; k < w; k++) begin
      v = xs(v);
      exp_q.push_back('{k, k / n, k % n, v});
    end
  endtask

  task automatic do_start(input logic [31:0] s,
                          input int num,
                          output int w);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.seed      = s;
    bus.num_items = 16'(num);
    push_model(s, num, w);
    max_addr = 0;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.seed      = $urandom;
    bus.num_items = 16'($urandom);
    chk("busy after accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input int w, input int cnt0, input string name);
    int cnt;
    cnt = cnt0;
    while (bus.done !== 1'b1 && cnt < w + 40) begin
      @(negedge clk);
      cnt++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles", name, cnt);
    end else begin
      chk({name, " latency"}, 32'(cnt), 32'(w + 1));
      chk({name, " busy at done"}, 32'(bus.busy), 32'd0);
      chk({name, " matw at done"}, 32'(bus.matw), 32'd0);
      chk({name, " queue drained"}, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk({name, " done pulse"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin : stim
    int w;
    int d0;
    int n0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.seed      = '0;
    bus.num_items = '0;
    repeat (2) @(negedge clk);
    chk("reset matw", 32'(bus.matw), 32'd0);
    chk("reset mat_a", 32'(bus.mat_a), 32'd0);
    chk("reset rand_num", bus.rand_num, 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    // basic load
    do_start(32'd1, 4, w);
    wait_done(w, 0, "basic");
    chk("basic first word", first_data, 32'h00042021);

    // zero seed
    do_start(32'd0, 3, w);
    wait_done(w, 0, "zero seed");
    chk("zero seed first word", first_data, 32'h00042021);

    // random loads
    for (int i = 0; i < 4; i++) begin
      do_start($urandom, $urandom_range(1, 20), w);
      wait_done(w, 0, "random");
    end

    // clamp
    n0 = nwrites;
    do_start($urandom, 2000, w);
    wait_done(w, 0, "clamp");
    chk("clamp writes", 32'(nwrites - n0), 32'(NCORE * DEPTH));
    chk("clamp max addr", 32'(max_addr), 32'(DEPTH - 1));

    // zero count
    n0 = nwrites;
    do_start($urandom, 0, w);
    wait_done(w, 0, "zero count");
    chk("zero count writes", 32'(nwrites - n0), 32'd0);

    // abort during write 10
    d0 = ndone;
    n0 = nwrites;
    do_start($urandom, 4, w);
    repeat (11) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort matw", 32'(bus.matw), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort writes", 32'(nwrites - n0), 32'd11);
    exp_q.delete();
    repeat (40) @(negedge clk);
    chk("abort no done", 32'(ndone - d0), 32'd0);
    chk("abort no more writes", 32'(nwrites - n0), 32'd11);
    do_start($urandom, 4, w);
    wait_done(w, 0, "after abort");

    // start while busy
    d0 = ndone;
    n0 = nwrites;
    do_start($urandom, 4, w);
    repeat (5) @(negedge clk);
    bus.start     = 1'b1;
    bus.seed      = $urandom;
    bus.num_items = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(w, 6, "start busy");
    repeat (20) @(negedge clk);
    chk("start busy one done", 32'(ndone - d0), 32'd1);
    chk("start busy writes", 32'(nwrites - n0), 32'(w));

    // reset mid-load at write 5
    do_start($urandom, 4, w);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst matw", 32'(bus.matw), 32'd0);
    chk("async rst mat_a", 32'(bus.mat_a), 32'd0);
    chk("async rst rand_num", bus.rand_num, 32'd0);
    chk("async rst busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_start(32'd1, 4, w);
    wait_done(w, 0, "after reset");
    chk("after reset first word", first_data, 32'h00042021);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
